frame_stream_writer: RTL and testbench

Writer side of the banked 8-bit framebuffer used by the VGA path. Accepts a pixel stream from the filter pipeline with a valid/ready handshake and a start-of-frame flag. Converts it into sequential framebuffer write cycles on the write port: WriteEnable, adreesMem and writeData, with bank bits [18:16] and word bits [15:0]. Raster order is the same one the display side reads (position = row*Width + column).

---
 rtl/frame_stream_writer_if.sv | 21 ++
 rtl/frame_stream_writer.sv | 87 ++++++++
 tb/tb_frame_stream_writer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/frame_stream_writer_if.sv
// Pixel stream handshake plus framebuffer write port shared by the writer and its neighbours.
// master: stream source / framebuffer side; slave: frame_stream_writer.
interface frame_stream_writer_if;
   logic        pix_valid;
   logic        pix_sof;
   logic [7:0]  pix_data;
   logic        pix_ready;
   logic        WriteEnable;
   logic [18:0] adreesMem;
   logic [17:0] writeData;

   modport master (
      output pix_valid, pix_sof, pix_data,
      input  pix_ready, WriteEnable, adreesMem, writeData
   );

   modport slave (
      input  pix_valid, pix_sof, pix_data,
      output pix_ready, WriteEnable, adreesMem, writeData
   );
endinterface

// File: rtl/frame_stream_writer.sv
// Turns a SOF-framed pixel stream into linear, registered framebuffer write cycles
// in raster order (row*Width + column) across the 19-bit banked address space.
module frame_stream_writer #(
   parameter int Width  = 640,
   parameter int Height = 480
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   frame_stream_writer_if.slave  pix,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  sync_err
);

   localparam logic [18:0] LAST = 19'(Width * Height - 1);

   typedef enum logic [1:0] {IDLE, ARM, WRITE, DONE} state_t;

   state_t      state;
   logic [18:0] cnt;
   logic        accept;
   logic        wr_pix;
   logic [18:0] pos;

   // A beat arriving with abort is dropped; in ARM only a SOF beat is written.
   assign accept = pix.pix_valid & pix.pix_ready & ~abort;
   assign wr_pix = accept & (pix.pix_sof | (state == WRITE));
   assign pos    = pix.pix_sof ? '0 : cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         cnt             <= '0;
         pix.pix_ready   <= 1'b0;
         pix.WriteEnable <= 1'b0;
         pix.adreesMem   <= '0;
         pix.writeData   <= '0;
         busy            <= 1'b0;
         frame_done      <= 1'b0;
         sync_err        <= 1'b0;
      end else begin
         pix.WriteEnable <= wr_pix;
         frame_done      <= 1'b0;
         if (wr_pix) begin
            pix.adreesMem <= pos;
            pix.writeData <= {10'b0, pix.pix_data};
            cnt           <= (pos == LAST) ? '0 : pos + 19'd1;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  state         <= ARM;
                  pix.pix_ready <= 1'b1;
                  busy          <= 1'b1;
                  sync_err      <= 1'b0;
                  cnt           <= '0;
               end
            end
            ARM, WRITE: begin
               if (abort) begin
                  state         <= IDLE;
                  pix.pix_ready <= 1'b0;
                  busy          <= 1'b0;
               end else if (wr_pix) begin
                  if (state == WRITE && pix.pix_sof && cnt != '0) sync_err <= 1'b1;
                  if (pos == LAST) begin
                     state         <= DONE;
                     pix.pix_ready <= 1'b0;
                     busy          <= 1'b0;
                  end else begin
                     state <= WRITE;
                  end
               end
            end
            DONE: begin
               // First DONE cycle carries the last write; the pulse follows it.
               if (frame_done) state <= IDLE;
               else            frame_done <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_frame_stream_writer.sv
// Randomized and directed bench for frame_stream_writer against a cycle-level reference model.
module tb_frame_stream_writer;
   localparam int W  = 4;
   localparam int H  = 2;
   localparam int N  = W * H;
   localparam int BW = 256;
   localparam int BH = 257;
   localparam int BN = BW * BH;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic start = 1'b0, abort = 1'b0;
   logic busy, frame_done, sync_err;
   logic b_start = 1'b0, b_abort = 1'b0;
   logic b_busy, b_done, b_err;

   frame_stream_writer_if s_if ();
   frame_stream_writer_if b_if ();

   frame_stream_writer #(.Width(W), .Height(H)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pix(s_if),
      .busy(busy), .frame_done(frame_done), .sync_err(sync_err)
   );

   frame_stream_writer #(.Width(BW), .Height(BH)) dut_big (
      .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort), .pix(b_if),
      .busy(b_busy), .frame_done(b_done), .sync_err(b_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // Reference model: mode 0 idle, 1 accepting (armed/writing), 2/3 the two post-frame cycles.
   int          m_mode;
   int          m_pos;    // next raster position, -1 while waiting for SOF
   bit          m_err;
   bit          e_we, e_ready, e_busy, e_done;
   logic [18:0] e_addr;
   logic [17:0] e_data;

   task automatic model_reset();
      m_mode = 0; m_pos = -1; m_err = 1'b0;
      e_we = 1'b0; e_ready = 1'b0; e_busy = 1'b0; e_done = 1'b0;
      e_addr = '0; e_data = '0;
   endtask

   task automatic model_step(input bit st, input bit ab, input bit v, input bit s, input logic [7:0] d);
      int p;
      bit wr;
      e_we = 1'b0; e_done = 1'b0; wr = 1'b0; p = 0;
      case (m_mode)
         0: if (st) begin m_mode = 1; m_pos = -1; m_err = 1'b0; end
         1: begin
            if (ab) m_mode = 0;
            else if (v) begin
               if (s) begin
                  if (m_pos > 0) m_err = 1'b1;
                  p = 0; wr = 1'b1;
               end else if (m_pos >= 0) begin
                  p = m_pos; wr = 1'b1;
               end
               if (wr) begin
                  e_we = 1'b1; e_addr = 19'(p); e_data = {10'b0, d};
                  if (p == N - 1) m_mode = 2;
                  else m_pos = p + 1;
               end
            end
         end
         2: begin m_mode = 3; e_done = 1'b1; end
         default: m_mode = 0;
      endcase
      e_ready = (m_mode == 1);
      e_busy  = (m_mode == 1);
   endtask

   task automatic check_all();
      chk("pix_ready",   32'(s_if.pix_ready),   32'(e_ready));
      chk("WriteEnable", 32'(s_if.WriteEnable), 32'(e_we));
      chk("adreesMem",   32'(s_if.adreesMem),   32'(e_addr));
      chk("writeData",   32'(s_if.writeData),   32'(e_data));
      chk("busy",        32'(busy),             32'(e_busy));
      chk("frame_done",  32'(frame_done),       32'(e_done));
      chk("sync_err",    32'(sync_err),         32'(m_err));
   endtask

   task automatic cyc(input bit st, input bit ab, input bit v, input bit s, input logic [7:0] d);
      start = st; abort = ab;
      s_if.pix_valid = v; s_if.pix_sof = s; s_if.pix_data = d;
      @(posedge clk);
      model_step(st, ab, v, s, d);
      #1;
      check_all();
      start = 1'b0; abort = 1'b0; s_if.pix_valid = 1'b0; s_if.pix_sof = 1'b0;
   endtask

   initial begin
      s_if.pix_valid = 1'b0; s_if.pix_sof = 1'b0; s_if.pix_data = '0;
      b_if.pix_valid = 1'b0; b_if.pix_sof = 1'b0; b_if.pix_data = '0;
      #1 rst_n = 1'b0;
      #2;
      model_reset();
      check_all();
      @(posedge clk); #1 rst_n = 1'b1;

      // Back-to-back frame, then start/abort during DONE (both ignored).
      cyc(1, 0, 0, 0, 8'h00);
      for (int i = 0; i < N; i++) cyc(0, 0, 1, i == 0, 8'(8'h10 + i));
      cyc(1, 0, 0, 0, 8'h00);
      cyc(0, 1, 0, 0, 8'h00);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 8'h00);

      // Non-SOF beats in ARM are discarded.
      cyc(1, 0, 0, 0, 8'h00);
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 8'(8'h50 + i));
      cyc(0, 0, 1, 1, 8'hAA);
      for (int i = 1; i < N; i++) cyc(0, 0, 1, 0, 8'(8'hB0 + i));
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 8'h00);

      // Valid toggling every other cycle.
      cyc(1, 0, 0, 0, 8'h00);
      for (int i = 0; i < 2 * N; i++) cyc(0, 0, (i % 2) == 0, i == 0, 8'(8'h20 + i));
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 8'h00);

      // Mid-frame SOF resync, then a later start clears sync_err.
      cyc(1, 0, 0, 0, 8'h00);
      for (int i = 0; i < 5; i++) cyc(0, 0, 1, i == 0, 8'(8'h30 + i));
      cyc(0, 0, 1, 1, 8'h77);
      for (int i = 1; i < N; i++) cyc(0, 0, 1, 0, 8'(8'h40 + i));
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 8'h00);
      cyc(1, 0, 0, 0, 8'h00);

      // Abort with a valid beat in the same cycle.
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, i == 0, 8'(8'h60 + i));
      cyc(0, 1, 1, 0, 8'h99);
      for (int i = 0; i < 2; i++) cyc(0, 0, 1, 0, 8'h98);

      // Simultaneous start and abort in IDLE: start wins; then reset mid-frame.
      cyc(1, 1, 0, 0, 8'h00);
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, i == 0, 8'(8'h70 + i));
      rst_n = 1'b0;
      #2;
      model_reset();
      check_all();
      @(posedge clk); #1;
      check_all();
      rst_n = 1'b1;

      // Randomized traffic.
      for (int i = 0; i < 600; i++)
         cyc(($urandom % 8) == 0, ($urandom % 32) == 0, ($urandom % 2) == 1,
             ($urandom % 6) == 0, 8'($urandom));
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 8'h00);

      // Large frame crossing the bank 0 -> bank 1 boundary.
      b_start = 1'b1;
      @(posedge clk); #1 b_start = 1'b0;
      chk("big_ready", 32'(b_if.pix_ready), 32'd1);
      for (int i = 0; i < BN; i++) begin
         b_if.pix_valid = 1'b1; b_if.pix_sof = (i == 0); b_if.pix_data = 8'(i);
         @(posedge clk); #1;
         chk("big_we", 32'(b_if.WriteEnable), 32'd1);
         chk("big_addr", 32'(b_if.adreesMem), 32'(i));
         if (i == 65535) chk("bank0_top", 32'(b_if.adreesMem), 32'h0FFFF);
         if (i == 65536) chk("bank1_w0", 32'(b_if.adreesMem), 32'h10000);
      end
      b_if.pix_valid = 1'b0; b_if.pix_sof = 1'b0;
      chk("big_ready_done", 32'(b_if.pix_ready), 32'd0);
      chk("big_done_early", 32'(b_done), 32'd0);
      @(posedge clk); #1;
      chk("big_done", 32'(b_done), 32'd1);
      chk("big_we_off", 32'(b_if.WriteEnable), 32'd0);
      chk("big_last_addr", 32'(b_if.adreesMem), 32'(BN - 1));
      @(posedge clk); #1;
      chk("big_done_once", 32'(b_done), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
